// File: rtl/mfda_seq_pkg.sv
// Shared types for the assay sequencer: FSM states, stage-table entry layout,
// and the rule that picks the first non-empty phase of a stage.
package mfda_seq_pkg;
    localparam int NUM_VALVES = 16;
    localparam int TIME_W     = 16;

    localparam int DWELL_LSB = 0;
    localparam int FILL_LSB  = TIME_W;
    localparam int MASK_LSB  = 2 * TIME_W;
    localparam int HEAT_BIT  = MASK_LSB + NUM_VALVES;
    localparam int MIX_BIT   = HEAT_BIT + 1;
    localparam int WDET_BIT  = MIX_BIT + 1;
    localparam int CFG_W     = WDET_BIT + 1;

    typedef enum logic [2:0] {
        IDLE, FILL, DWELL, WAIT_DET, NEXT, ERROR
    } state_e;

    typedef struct packed {
        logic                  wait_det;
        logic                  mix;
        logic                  heat;
        logic [NUM_VALVES-1:0] valve_mask;
        logic [TIME_W-1:0]     fill_t;
        logic [TIME_W-1:0]     dwell_t;
    } stage_cfg_t;

    // Phase to enter after leaving 'cur'; zero-length phases are skipped so an
    // all-zero stage falls straight through to NEXT.
    function automatic state_e phase_after(input stage_cfg_t c, input state_e cur);
        if (cur != FILL && cur != DWELL && c.fill_t != '0) return FILL;
        if (cur != DWELL && c.dwell_t != '0)               return DWELL;
        if (c.wait_det)                                    return WAIT_DET;
        return NEXT;
    endfunction
endpackage

// File: rtl/mfda_phase_timer.sv
// Loadable saturating down-counter; expire_o is high while the count is zero.
module mfda_phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)             cnt_d = load_val_i;
        else if (cnt_q != '0)   cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expire_o = (cnt_q == '0);
endmodule

// File: rtl/mfda_assay_sequencer.sv
// Steps a microfluidic assay through its stage table, driving valve/pump/
// heater/mixer enables per stage with optional detector handshake.
module mfda_assay_sequencer
    import mfda_seq_pkg::*;
#(
    parameter int NUM_STAGES = 7,
    parameter int DET_TMO    = 1024,
    localparam int SA        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [SA-1:0]         cfg_addr,
    input  logic [CFG_W-1:0]      cfg_data,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  det_valid,
    output logic [NUM_VALVES-1:0] valve_en,
    output logic                  pump_en,
    output logic                  heat_en,
    output logic                  mix_en,
    output logic [SA-1:0]         stage_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam logic [SA-1:0] LAST = SA'(NUM_STAGES - 1);

    state_e          state_q, state_d;
    logic [SA-1:0]   stage_q, stage_d;
    stage_cfg_t      tbl_q [NUM_STAGES];
    stage_cfg_t      cfg_d;

    logic                  done_q, done_d, err_q, err_d, busy_q, busy_d;
    logic [NUM_VALVES-1:0] valve_q, valve_d;
    logic                  pump_q, pump_d, heat_q, heat_d, mix_q, mix_d;

    logic              tmr_ld, tmr_exp;
    logic [TIME_W-1:0] tmr_val;

    mfda_phase_timer #(.W(TIME_W)) u_tmr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_ld),
        .load_val_i (tmr_val),
        .expire_o   (tmr_exp)
    );

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        done_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            IDLE, ERROR: if (start) begin
                stage_d = '0;
                state_d = phase_after(tbl_q[0], IDLE);
                err_d   = 1'b0;
            end
            FILL:  if (tmr_exp) state_d = phase_after(tbl_q[stage_q], FILL);
            DWELL: if (tmr_exp) state_d = phase_after(tbl_q[stage_q], DWELL);
            WAIT_DET: begin
                if (det_valid) state_d = NEXT;
                else if (tmr_exp) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end
            end
            NEXT: begin
                if (stage_q == LAST) begin
                    state_d = IDLE;
                    stage_d = '0;
                    done_d  = 1'b1;
                end else begin
                    stage_d = stage_q + SA'(1);
                    state_d = phase_after(tbl_q[stage_d], NEXT);
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            stage_d = '0;
            done_d  = 1'b0;
            err_d   = err_q;
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        cfg_d   = tbl_q[stage_d];
        tmr_ld  = (state_d != state_q);
        tmr_val = '0;
        unique case (state_d)
            FILL:     tmr_val = cfg_d.fill_t - TIME_W'(1);
            DWELL:    tmr_val = cfg_d.dwell_t - TIME_W'(1);
            WAIT_DET: tmr_val = TIME_W'(DET_TMO - 1);
            default:  tmr_val = '0;
        endcase
        busy_d  = !(state_d inside {IDLE, ERROR});
        valve_d = (state_d == FILL) ? cfg_d.valve_mask : '0;
        pump_d  = (state_d == FILL);
        heat_d  = (state_d == DWELL) && cfg_d.heat;
        mix_d   = (state_d == DWELL) && cfg_d.mix;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            stage_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            valve_q <= '0;
            pump_q  <= 1'b0;
            heat_q  <= 1'b0;
            mix_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            valve_q <= valve_d;
            pump_q  <= pump_d;
            heat_q  <= heat_d;
            mix_q   <= mix_d;
        end
    end

    // Table is frozen while a run is in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STAGES; i++) tbl_q[i] <= '0;
        end else if (cfg_we && !busy_q && (32'(cfg_addr) < NUM_STAGES)) begin
            tbl_q[cfg_addr] <= cfg_data;
        end
    end

    assign valve_en  = valve_q;
    assign pump_en   = pump_q;
    assign heat_en   = heat_q;
    assign mix_en    = mix_q;
    assign stage_idx = stage_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_mfda_assay_sequencer.sv
// Scoreboard bench: each run's expected per-cycle output trace is built from a
// stage-by-stage model and queued; a negedge monitor pops and compares.
module tb_mfda_assay_sequencer;
    import mfda_seq_pkg::*;

    localparam int NS  = 7;
    localparam int TMO = 1024;

    logic             clk, rst, cfg_we, start, abort, det_valid;
    logic [2:0]       cfg_addr;
    logic [CFG_W-1:0] cfg_data;
    logic [15:0]      valve_en;
    logic             pump_en, heat_en, mix_en, busy, done, err;
    logic [2:0]       stage_idx;

    mfda_assay_sequencer #(.NUM_STAGES(NS), .DET_TMO(TMO)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .start(start), .abort(abort), .det_valid(det_valid),
        .valve_en(valve_en), .pump_en(pump_en), .heat_en(heat_en), .mix_en(mix_en),
        .stage_idx(stage_idx), .busy(busy), .done(done), .err(err)
    );

    typedef struct packed {
        logic [15:0] valve;
        logic        pump, heat, mix;
        logic [2:0]  stage;
        logic        busy, done, err;
    } obs_t;

    int    checks = 0, errors = 0, pops = 0;
    obs_t  exp_q[$];
    obs_t  tr[$];
    bit    det_seq[8192];

    int          m_fill[NS], m_dwell[NS];
    logic [15:0] m_mask[NS];
    bit          m_heat[NS], m_mix[NS], m_wd[NS];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front();
            a = {valve_en, pump_en, heat_en, mix_en, stage_idx, busy, done, err};
            checks++;
            pops++;
            if (a !== e)
                begin
                    errors++;
                    $display("FAIL trace#%0d got valve=%h p=%b h=%b m=%b stg=%0d busy=%b done=%b err=%b exp valve=%h p=%b h=%b m=%b stg=%0d busy=%b done=%b err=%b",
                             pops, a.valve, a.pump, a.heat, a.mix, a.stage, a.busy, a.done, a.err,
                             e.valve, e.pump, e.heat, e.mix, e.stage, e.busy, e.done, e.err);
                end
        end
    end

    function automatic obs_t ob(logic [15:0] v, bit p, bit h, bit m, int s, bit b, bit d, bit e);
        return {v, p, h, m, 3'(s), b, d, e};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, expv);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < NS; s++) begin
            m_fill[s] = 0; m_dwell[s] = 0; m_mask[s] = '0;
            m_heat[s] = 0; m_mix[s] = 0; m_wd[s] = 0;
        end
    endtask

    task automatic cfg_write(input int a, input int f, input int d, input logic [15:0] mk,
                             input bit h, input bit m, input bit w);
        cfg_addr = 3'(a);
        cfg_data = {w, m, h, mk, TIME_W'(f), TIME_W'(d)};
        cfg_we   = 1'b1;
        @(posedge clk); #1;
        cfg_we   = 1'b0;
        if (a < NS) begin
            m_fill[a] = f; m_dwell[a] = d; m_mask[a] = mk;
            m_heat[a] = h; m_mix[a] = m; m_wd[a] = w;
        end
    endtask

    task automatic clear_table();
        for (int s = 0; s < NS; s++) cfg_write(s, 0, 0, 16'h0, 0, 0, 0);
    endtask

    task automatic det_fill(input bit rnd);
        for (int i = 0; i < 8192; i++) det_seq[i] = rnd ? ($urandom_range(0, 5) == 0) : 1'b0;
    endtask

    // Cycle-by-cycle expectation of a full run, starting the cycle after start.
    task automatic build_trace();
        bit got;
        tr.delete();
        for (int s = 0; s < NS; s++) begin
            for (int k = 0; k < m_fill[s]; k++)  tr.push_back(ob(m_mask[s], 1, 0, 0, s, 1, 0, 0));
            for (int k = 0; k < m_dwell[s]; k++) tr.push_back(ob(16'h0, 0, m_heat[s], m_mix[s], s, 1, 0, 0));
            if (m_wd[s]) begin
                got = 0;
                for (int k = 0; k < TMO && !got; k++) begin
                    got = det_seq[tr.size()];
                    tr.push_back(ob(16'h0, 0, 0, 0, s, 1, 0, 0));
                end
                if (!got) begin
                    repeat (2) tr.push_back(ob(16'h0, 0, 0, 0, s, 0, 0, 1));
                    return;
                end
            end
            tr.push_back(ob(16'h0, 0, 0, 0, s, 1, 0, 0));
        end
        tr.push_back(ob(16'h0, 0, 0, 0, 0, 0, 1, 0));
        tr.push_back(ob(16'h0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic run(input int abort_at, input bit noise);
        int ab;
        ab = abort_at;
        build_trace();
        if (ab >= 0 && ab < tr.size() && tr[ab].busy) begin
            while (tr.size() > ab + 1) void'(tr.pop_back());
            repeat (2) tr.push_back(ob(16'h0, 0, 0, 0, 0, 0, 0, 0));
        end else ab = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        foreach (tr[i]) exp_q.push_back(tr[i]);
        for (int j = 0; j < tr.size(); j++) begin
            det_valid = det_seq[j];
            abort     = (j == ab);
            if (noise && tr[j].busy) begin
                start    = ($urandom_range(0, 1) == 1);
                cfg_we   = ($urandom_range(0, 2) == 0);
                cfg_addr = 3'($urandom_range(0, 7));
                cfg_data = CFG_W'({$urandom(), $urandom()});
            end else begin
                start  = 1'b0;
                cfg_we = 1'b0;
            end
            @(posedge clk); #1;
        end
        det_valid = 1'b0; abort = 1'b0; start = 1'b0; cfg_we = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain left=%0d exp 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst = 1'b1; cfg_we = 0; cfg_addr = '0; cfg_data = '0;
        start = 0; abort = 0; det_valid = 0;
        model_clear();
        det_fill(0);
        #12;
        chk("reset_outputs", {7'h0, valve_en, pump_en, heat_en, mix_en, stage_idx, busy, done, err}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Stage 0 fill/dwell example: 3+2+1+6 busy cycles, then done.
        cfg_write(0, 3, 2, 16'h0003, 1, 0, 0);
        run(-1, 0);

        // Detector arrives on the 5th WAIT_DET cycle of stage 2.
        clear_table();
        cfg_write(2, 0, 0, 16'h0, 0, 0, 1);
        det_fill(0);
        det_seq[6] = 1'b1;
        run(-1, 0);

        // Detector never arrives: timeout into ERROR.
        det_fill(0);
        run(-1, 0);
        chk("err_sticky", {31'h0, err}, 32'h1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_in_error_keeps_err", {27'h0, err, busy, stage_idx}, {27'h0, 1'b1, 1'b0, 3'd0});
        @(posedge clk); #1;
        cfg_write(0, 2, 1, 16'h00f0, 0, 1, 0);
        cfg_write(2, 0, 0, 16'h0, 0, 0, 0);
        run(-1, 0);

        // Abort mid-DWELL of stage 3.
        clear_table();
        cfg_write(3, 2, 10, 16'h1234, 0, 1, 0);
        run(3 + 2 + 4, 0);

        // Writes during a run are ignored; the same write when idle sticks.
        clear_table();
        cfg_write(5, 1, 1, 16'h8001, 1, 1, 0);
        run(-1, 1);
        run(-1, 0);
        cfg_write(5, 4, 3, 16'h0a50, 0, 1, 0);
        cfg_write(7, 5, 5, 16'hffff, 1, 1, 1);
        run(-1, 0);

        // start together with abort in IDLE.
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", {25'h0, busy, pump_en, valve_en[4:0]}, 32'h0);
        @(posedge clk); #1;
        chk("start_abort_idle2", {30'h0, busy, done}, 32'h0);

        // Randomized runs with detector noise, ignored starts/writes and aborts.
        for (int r = 0; r < 40; r++) begin
            for (int s = 0; s < NS; s++)
                cfg_write(s, $urandom_range(0, 4), $urandom_range(0, 4), 16'($urandom()),
                          ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 3) == 0));
            det_fill(1);
            run(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1, 1);
        end

        // Reset in the middle of a FILL.
        clear_table();
        cfg_write(0, 20, 0, 16'h00ff, 0, 0, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("fill_before_reset", {15'h0, valve_en, pump_en}, {15'h0, 16'h00ff, 1'b1});
        #2 rst = 1'b1;
        #1;
        chk("reset_mid_fill", {7'h0, valve_en, pump_en, heat_en, mix_en, stage_idx, busy, done, err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        det_fill(0);
        @(posedge clk); #1;
        run(-1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
